// File: rtl/ql_cfg_pkg.sv
// Shared state type and sizing helpers for the memory-bank configuration loader.
package ql_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } cfg_state_e;

  // Input words needed to fill one bit-line row.
  function automatic int unsigned words_per_row(input int unsigned bl_w,
                                                input int unsigned data_w);
    return (bl_w + data_w - 1) / data_w;
  endfunction

  // Bits needed to count 0..n-1 (never less than one).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ql_mb_bl_assembler.sv
// Bit-line row register: slots each accepted word into its slice and drops
// bits that fall past the end of the row.
module ql_mb_bl_assembler
  import ql_cfg_pkg::*;
#(
  parameter int unsigned BL_WIDTH   = 514,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORD_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [WORD_W-1:0]     word_idx_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  clear_i,
  output logic [BL_WIDTH-1:0]   bl_o
);

  logic [BL_WIDTH-1:0] bl_q, bl_d;

  // Each bit owns one (word, bit) position; the tail of the last word has no owner.
  always_comb begin
    bl_d = bl_q;
    if (clear_i) begin
      bl_d = '0;
    end else if (wr_en_i) begin
      for (int unsigned b = 0; b < BL_WIDTH; b++) begin
        if (word_idx_i == WORD_W'(b / DATA_WIDTH)) begin
          bl_d[b] = data_i[b % DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bl_q <= '0;
    end else begin
      bl_q <= bl_d;
    end
  end

  assign bl_o = bl_q;

endmodule

// File: rtl/ql_mb_config_loader.sv
// Streams the bitstream into BL rows and pulses one WL per row, then releases
// the fabric from reset once every row is programmed.
module ql_mb_config_loader
  import ql_cfg_pkg::*;
#(
  parameter int unsigned BL_WIDTH     = 514,
  parameter int unsigned WL_WIDTH     = 407,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BL_WIDTH-1:0]   bl,
  output logic [WL_WIDTH-1:0]   wl,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  fabric_resetn
);

  localparam int unsigned WORDS   = words_per_row(BL_WIDTH, DATA_WIDTH);
  localparam int unsigned WORD_W  = cnt_width(WORDS + 1);
  localparam int unsigned ROW_W   = cnt_width(WL_WIDTH);
  localparam int unsigned TMR_MAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

  cfg_state_e          state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [WL_WIDTH-1:0] wl_q, wl_d;
  logic                in_ready_q, busy_q, done_q, resetn_q;
  logic                xfer_c;

  assign xfer_c = in_valid && in_ready_q;

  // Next-state and counter updates.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    word_d  = word_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          row_d   = '0;
          word_d  = '0;
        end
      end
      ST_LOAD: begin
        if (xfer_c) begin
          word_d = word_q + WORD_W'(1);
          if (word_q == WORD_W'(WORDS - 1)) begin
            state_d = ST_SETUP;
            tmr_d   = '0;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_q == TMR_W'(SETUP_CYCLES - 1)) begin
          state_d = ST_PULSE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_PULSE: begin
        if (tmr_q == TMR_W'(PULSE_CYCLES - 1)) begin
          state_d = ST_HOLD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_HOLD: begin
        if (row_q == ROW_W'(WL_WIDTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
          row_d   = row_q + ROW_W'(1);
          word_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-hot WL for the row being programmed, only while pulsing.
  always_comb begin
    wl_d = '0;
    for (int unsigned i = 0; i < WL_WIDTH; i++) begin
      wl_d[i] = (state_d == ST_PULSE) && (row_d == ROW_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      word_q     <= '0;
      tmr_q      <= '0;
      wl_q       <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      resetn_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      word_q     <= word_d;
      tmr_q      <= tmr_d;
      wl_q       <= wl_d;
      in_ready_q <= (state_d == ST_LOAD);
      busy_q     <= !((state_d == ST_IDLE) || (state_d == ST_DONE));
      done_q     <= (state_d == ST_DONE);
      resetn_q   <= (state_d == ST_DONE);
    end
  end

  ql_mb_bl_assembler #(
    .BL_WIDTH  (BL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .WORD_W    (WORD_W)
  ) u_bl_asm (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (xfer_c),
    .word_idx_i(word_q),
    .data_i    (in_data),
    .clear_i   (state_d == ST_DONE),
    .bl_o      (bl)
  );

  assign in_ready      = in_ready_q;
  assign wl            = wl_q;
  assign busy          = busy_q;
  assign cfg_done      = done_q;
  assign fabric_resetn = resetn_q;

endmodule
